lsu_mem_access: RTL and testbench

- Load/store unit between the execute stage and the word-only data memory (64 x 32-bit, word-addressed via ma>>2).
- Accepts one request at a time: byte, halfword or word loads and stores.
- Drives the memory's mwr/moe/ma/mwd, consumes its mrd, and returns extracted, extended load data.
- Sub-word stores are done as read-modify-write, because the memory only writes whole words.

---
 rtl/lsu_mem_access.sv | 145 ++++++++++++++
 tb/tb_lsu_mem_access.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_access.sv
// Load/store unit in front of a word-only data memory.
// Sub-word stores are done as read-modify-write; loads return extended lane data.
module lsu_mem_access #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              mwr,
  output logic              moe,
  output logic [ADDR_W-1:0] ma,
  output logic [DATA_W-1:0] mwd,
  input  logic [DATA_W-1:0] mrd
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_RMW_RD = 3'd2;
  localparam logic [2:0] S_STORE  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [1:0]        size_q, size_d;
  logic              sgn_q, sgn_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] wbuf_q, wbuf_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  logic              bad_req;
  logic [4:0]        lsh;
  logic [DATA_W-1:0] lane, mask, merged, load_val;

  assign bad_req = (req_size == 2'b11) ||
                   (req_size == 2'b01 && req_addr[0]) ||
                   (req_size == 2'b10 && req_addr[1:0] != 2'b00);

  // Lane position: byte offset for bytes, halfword offset for halves.
  always_comb begin
    lsh    = (size_q == 2'b00) ? {addr_q[1:0], 3'b000} : {addr_q[1], 4'b0000};
    mask   = ((size_q == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF) << lsh;
    merged = (mrd & ~mask) | ((wdata_q << lsh) & mask);
    lane   = mrd >> lsh;
    case (size_q)
      2'b00:   load_val = {{(DATA_W-8){sgn_q & lane[7]}}, lane[7:0]};
      2'b01:   load_val = {{(DATA_W-16){sgn_q & lane[15]}}, lane[15:0]};
      default: load_val = mrd;
    endcase
  end

  always_comb begin
    state_d = state_q;
    size_d  = size_q;
    sgn_d   = sgn_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wbuf_d  = wbuf_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          size_d  = req_size;
          sgn_d   = req_signed;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          if (bad_req) begin
            state_d = S_DONE;
            rdata_d = '0;
            err_d   = 1'b1;
          end else if (!req_we) begin
            state_d = S_LOAD;
          end else if (req_size == 2'b10) begin
            state_d = S_STORE;
            wbuf_d  = req_wdata;
          end else begin
            state_d = S_RMW_RD;
          end
        end
      end
      S_LOAD: begin
        rdata_d = load_val;
        err_d   = 1'b0;
        state_d = S_DONE;
      end
      S_RMW_RD: begin
        wbuf_d  = merged;
        state_d = S_STORE;
      end
      S_STORE: begin
        rdata_d = '0;
        err_d   = 1'b0;
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Memory-side strobes come from state only, so a reset kills mwr at once.
  always_comb begin
    req_ready  = (state_q == S_IDLE);
    resp_valid = (state_q == S_DONE);
    moe        = (state_q == S_LOAD) || (state_q == S_RMW_RD);
    mwr        = (state_q == S_STORE);
    ma         = (moe || mwr) ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    mwd        = mwr ? wbuf_q : '0;
    resp_rdata = rdata_q;
    resp_err   = err_q;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      size_q  <= '0;
      sgn_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wbuf_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      size_q  <= size_d;
      sgn_q   <= sgn_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wbuf_q  <= wbuf_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_lsu_mem_access.sv
// Scoreboard bench for lsu_mem_access with a 64-word memory model.
module tb_lsu_mem_access;
  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err, mwr, moe;
  logic [31:0] resp_rdata, ma, mwd, mrd;

  always #5 clock = ~clock;

  lsu_mem_access #(.ADDR_W(32), .DATA_W(32)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .mwr(mwr), .moe(moe), .ma(ma), .mwd(mwd), .mrd(mrd)
  );

  logic [31:0] mem [64] = '{default: 32'd0};
  always @(posedge clock) if (mwr && ma[31:8] == 24'd0) mem[ma[7:2]] <= mwd;
  assign mrd = (moe && ma[31:8] == 24'd0) ? mem[ma[7:2]] : 32'd0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;
  exp_t q[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int nwr   = 0;
  int noe   = 0;
  int acc   = 0;
  logic [31:0] last_ma  = '0;
  logic [31:0] last_mwd = '0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: counts memory strobes and checks each response against the queue.
  always @(negedge clock) begin
    exp_t e;
    if (mwr) begin nwr++; last_ma = ma; last_mwd = mwd; end
    if (moe) noe++;
    if (reset && resp_valid) begin
      if (q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_resp: got resp_valid at cycle %0d expected none", cyc);
      end else begin
        e = q.pop_front();
        chk("resp_rdata", resp_rdata, e.rdata);
        chk("resp_err", {31'd0, resp_err}, {31'd0, e.err});
        chk("resp_cycle", cyc, e.cyc);
      end
    end
  end

  // Presents a request and keeps req_valid high until accepted; returns at the
  // negedge after the accepting edge with req_valid still asserted.
  task automatic issue(input logic we, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input logic exp_err, input int lat);
    bit done = 0;
    req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd;
    for (int i = 0; i < 50 && !done; i++) begin
      if (req_ready) begin
        acc = cyc;
        q.push_back('{exp_rd, exp_err, cyc + lat});
        done = 1;
      end
      @(negedge clock);
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL accept_timeout: got req_ready=0 for 50 cycles expected 1");
    end
  endtask

  task automatic drain();
    req_valid = 1'b0;
    for (int i = 0; i < 30 && q.size() != 0; i++) @(negedge clock);
    if (q.size() != 0) begin
      total++; bad++;
      $display("FAIL resp_timeout: got %0d pending expected 0", q.size());
      q.delete();
    end
    @(negedge clock);
  endtask

  initial begin
    int wr0, oe0, acc1;
    reset = 1'b0; req_valid = 0; req_we = 0; req_size = 0; req_signed = 0;
    req_addr = 0; req_wdata = 0;
    #12;
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_mwr_moe", {30'd0, mwr, moe}, 32'd0);
    chk("rst_ma", ma, 32'd0);
    chk("rst_mwd", mwd, 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_err", {31'd0, resp_err}, 32'd0);
    @(negedge clock); reset = 1'b1; @(negedge clock);
    chk("rst_ready", {31'd0, req_ready}, 32'd1);

    // Word store
    wr0 = nwr; oe0 = noe;
    issue(1, 2'b10, 0, 32'h4, 32'h8899AABB, 32'h0, 0, 2);
    drain();
    chk("sw_nwr", nwr - wr0, 1);
    chk("sw_noe", noe - oe0, 0);
    chk("sw_ma", last_ma, 32'h4);
    chk("sw_mwd", last_mwd, 32'h8899AABB);
    chk("sw_mem1", mem[1], 32'h8899AABB);

    // Loads
    oe0 = noe;
    issue(0, 2'b00, 1, 32'h5, 0, 32'hFFFFFFAA, 0, 2); drain();
    chk("lb_noe", noe - oe0, 1);
    issue(0, 2'b00, 0, 32'h5, 0, 32'h000000AA, 0, 2); drain();
    issue(0, 2'b00, 1, 32'h4, 0, 32'hFFFFFFBB, 0, 2); drain();
    issue(0, 2'b01, 1, 32'h6, 0, 32'hFFFF8899, 0, 2); drain();
    issue(0, 2'b01, 0, 32'h6, 0, 32'h00008899, 0, 2); drain();
    issue(0, 2'b10, 0, 32'h4, 0, 32'h8899AABB, 0, 2); drain();

    // Sub-word stores
    wr0 = nwr; oe0 = noe;
    issue(1, 2'b00, 0, 32'h6, 32'h12345677, 32'h0, 0, 3); drain();
    chk("sb_nwr", nwr - wr0, 1);
    chk("sb_noe", noe - oe0, 1);
    chk("sb_mwd", last_mwd, 32'h8877AABB);
    issue(0, 2'b10, 0, 32'h4, 0, 32'h8877AABB, 0, 2); drain();
    issue(1, 2'b01, 0, 32'h2, 32'h0000BEEF, 32'h0, 0, 3); drain();
    chk("sh_mem0", mem[0], 32'hBEEF0000);
    issue(0, 2'b00, 0, 32'h3, 0, 32'h000000BE, 0, 2); drain();

    // Errors
    wr0 = nwr; oe0 = noe;
    issue(0, 2'b10, 0, 32'h6, 0, 32'h0, 1, 1); drain();
    issue(1, 2'b01, 0, 32'h3, 32'hFFFF, 32'h0, 1, 1); drain();
    issue(1, 2'b11, 0, 32'h8, 32'h1, 32'h0, 1, 1); drain();
    issue(0, 2'b11, 1, 32'h4, 0, 32'h0, 1, 1); drain();
    chk("err_nwr", nwr - wr0, 0);
    chk("err_noe", noe - oe0, 0);

    // Out of range
    issue(1, 2'b10, 0, 32'h1000, 32'hDEADBEEF, 32'h0, 0, 2); drain();
    issue(0, 2'b10, 0, 32'h1000, 0, 32'h0, 0, 2); drain();
    chk("oor_mem0", mem[0], 32'hBEEF0000);

    // Reset in RMW_RD
    wr0 = nwr;
    issue(1, 2'b00, 0, 32'h4, 32'h55, 32'h0, 0, 3);
    reset = 1'b0; req_valid = 1'b0;
    void'(q.pop_back());
    #1;
    chk("rst_mid_mwr", {31'd0, mwr}, 32'd0);
    chk("rst_mid_resp", {31'd0, resp_valid}, 32'd0);
    @(negedge clock); @(negedge clock);
    reset = 1'b1;
    #1 chk("rst_mid_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clock); @(negedge clock);
    chk("rst_mid_nwr", nwr - wr0, 0);
    chk("rst_mid_mem1", mem[1], 32'h8877AABB);

    // Back-to-back with req_valid held
    issue(0, 2'b10, 0, 32'h4, 0, 32'h8877AABB, 0, 2);
    acc1 = acc;
    issue(0, 2'b00, 0, 32'h7, 0, 32'h00000088, 0, 2);
    chk("b2b_accept", acc - acc1, 3);
    issue(1, 2'b00, 0, 32'h9, 32'hA5, 32'h0, 0, 3);
    chk("b2b_accept2", acc - acc1, 6);
    drain();
    chk("b2b_mem2", mem[2], 32'h0000A500);
    repeat (3) @(negedge clock);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
